// File: rtl/sram_like_arbiter.sv
// Two-master to one-slave SRAM-like arbiter: data side has fixed priority, the grant is held
// until the address handshake completes, and an order FIFO routes in-order responses back.
module sram_like_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        resp_err
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  // Lock state folds the lock flag and its owner (inst=0, data=1) into one encoding.
  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } lock_state_t;

  lock_state_t      r_state;
  lock_state_t      w_state_nxt;

  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [DEPTH-1:0] r_order;
  logic             r_resp_err;

  logic             w_sel;
  logic             w_sel_req;
  logic             w_full;
  logic             w_fire;
  logic             w_push;
  logic             w_pop;
  logic             w_head;

  // Arbitration stage: a held lock wins, otherwise data beats inst.
  always_comb begin
    w_sel = 1'b0;
    case (r_state)
      ST_LOCK_INST: w_sel = 1'b0;
      ST_LOCK_DATA: w_sel = 1'b1;
      default:      w_sel = data_req;
    endcase
  end

  assign w_sel_req = w_sel ? data_req : inst_req;
  assign w_full    = (r_count == CNT_FULL);

  assign mem_req   = w_sel_req & ~w_full & ~reset;
  assign mem_wr    = w_sel ? data_wr    : inst_wr;
  assign mem_size  = w_sel ? data_size  : inst_size;
  assign mem_addr  = w_sel ? data_addr  : inst_addr;
  assign mem_wstrb = w_sel ? data_wstrb : inst_wstrb;
  assign mem_wdata = w_sel ? data_wdata : inst_wdata;

  assign w_fire       = mem_req & mem_addr_ok;
  assign inst_addr_ok = w_fire & ~w_sel;
  assign data_addr_ok = w_fire &  w_sel;

  // Response stage: the FIFO head names the owner of the oldest outstanding transfer.
  assign w_push = w_fire;
  assign w_head = r_order[r_rd_ptr];
  assign w_pop  = mem_data_ok & (r_count != '0);

  assign inst_data_ok = w_pop & ~w_head;
  assign data_data_ok = w_pop &  w_head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign resp_err     = r_resp_err;

  always_comb begin
    w_state_nxt = r_state;
    if (w_fire) begin
      w_state_nxt = ST_FREE;
    end else if (mem_req) begin
      w_state_nxt = w_sel ? ST_LOCK_DATA : ST_LOCK_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FREE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (mem_data_ok && (r_count == '0)) begin
        r_resp_err <= 1'b1;
      end
    end
  end

  // Owner bits are payload; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_order[r_wr_ptr] <= w_sel;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter: arbitration, lock, FIFO full,
// pointer wrap, response routing and the sticky response-error flag.
module tb_sram_like_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  sram_like_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wstrb = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    inst_req = 1; inst_addr = 32'h1C00_0000;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (inst_addr_ok !== 1'b0) begin n_bad++; $display("FAIL rst_inst_addr_ok: got %b want 0", inst_addr_ok); end
    tick();
    reset = 1'b0; inst_req = 0;
    #1;
    n_cmp++; if (dut.r_count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", dut.r_count); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    n_cmp++; if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      n_bad++; $display("FAIL rst_handshakes: got %b want 00000",
                        {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    tick();
  endtask

  task automatic test_single_inst();
    inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
    #1;
    n_cmp++; if (mem_addr !== 32'h1C00_0000) begin n_bad++; $display("FAIL single_mem_addr: got %h want 1c000000", mem_addr); end
    n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_bad++; $display("FAIL single_addr_ok: got %b want 10", {inst_addr_ok, data_addr_ok}); end
    tick();
    inst_req = 0; mem_addr_ok = 0;
    #1;
    n_cmp++; if (dut.r_count !== 3'd1) begin n_bad++; $display("FAIL single_count1: got %0d want 1", dut.r_count); end
    n_cmp++; if (inst_data_ok !== 1'b0) begin n_bad++; $display("FAIL single_early_data_ok: got %b want 0", inst_data_ok); end
    tick();
    mem_data_ok = 1; mem_rdata = 32'h0280_0C0C;
    #1;
    n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_bad++; $display("FAIL single_data_ok: got %b want 10", {inst_data_ok, data_data_ok}); end
    n_cmp++; if (inst_rdata !== 32'h0280_0C0C) begin n_bad++; $display("FAIL single_rdata: got %h want 02800c0c", inst_rdata); end
    tick();
    mem_data_ok = 0;
    #1;
    n_cmp++; if (dut.r_count !== 3'd0) begin n_bad++; $display("FAIL single_count0: got %0d want 0", dut.r_count); end
    tick();
  endtask

  task automatic test_priority();
    inst_req = 1; inst_addr = 32'h1C00_0004;
    data_req = 1; data_wr = 1; data_addr = 32'h0000_1000; data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
    mem_addr_ok = 1;
    #1;
    n_cmp++; if (mem_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL prio_mem_addr: got %h want 00001000", mem_addr); end
    n_cmp++; if ({mem_wr, mem_wstrb} !== 5'b1_1111) begin n_bad++; $display("FAIL prio_wr_strb: got %b want 11111", {mem_wr, mem_wstrb}); end
    n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin n_bad++; $display("FAIL prio_addr_ok0: got %b want 01", {inst_addr_ok, data_addr_ok}); end
    tick();
    data_req = 0; data_wr = 0;
    #1;
    n_cmp++; if (mem_addr !== 32'h1C00_0004) begin n_bad++; $display("FAIL prio_mem_addr1: got %h want 1c000004", mem_addr); end
    n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_bad++; $display("FAIL prio_addr_ok1: got %b want 10", {inst_addr_ok, data_addr_ok}); end
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA_0001;
    #1;
    n_cmp++; if (dut.r_count !== 3'd2) begin n_bad++; $display("FAIL prio_count: got %0d want 2", dut.r_count); end
    n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_bad++; $display("FAIL prio_resp0: got %b want 01", {inst_data_ok, data_data_ok}); end
    tick();
    mem_rdata = 32'hBBBB_0002;
    #1;
    n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_bad++; $display("FAIL prio_resp1: got %b want 10", {inst_data_ok, data_data_ok}); end
    n_cmp++; if (inst_rdata !== 32'hBBBB_0002) begin n_bad++; $display("FAIL prio_rdata1: got %h want bbbb0002", inst_rdata); end
    tick();
    set_idle();
    #1;
    n_cmp++; if (dut.r_count !== 3'd0) begin n_bad++; $display("FAIL prio_count_end: got %0d want 0", dut.r_count); end
    tick();
  endtask

  task automatic test_lock();
    inst_req = 1; inst_addr = 32'h1C00_0008; mem_addr_ok = 0;
    #1;
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h1C00_0008}) begin n_bad++; $display("FAIL lock_c0: got %b/%h want 1/1c000008", mem_req, mem_addr); end
    tick();
    data_req = 1; data_addr = 32'h0000_2000;
    for (int c = 1; c <= 2; c++) begin
      #1;
      n_cmp++; if (mem_addr !== 32'h1C00_0008) begin n_bad++; $display("FAIL lock_hold_c%0d: got %h want 1c000008", c, mem_addr); end
      n_cmp++; if (data_addr_ok !== 1'b0) begin n_bad++; $display("FAIL lock_data_wait_c%0d: got %b want 0", c, data_addr_ok); end
      tick();
    end
    mem_addr_ok = 1;
    #1;
    n_cmp++; if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b10, 32'h1C00_0008}) begin
      n_bad++; $display("FAIL lock_fire_c3: got %b%b/%h want 10/1c000008", inst_addr_ok, data_addr_ok, mem_addr); end
    tick();
    inst_req = 0;
    #1;
    n_cmp++; if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b01, 32'h0000_2000}) begin
      n_bad++; $display("FAIL lock_data_c4: got %b%b/%h want 01/00002000", inst_addr_ok, data_addr_ok, mem_addr); end
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_bad++; $display("FAIL lock_resp0: got %b want 10", {inst_data_ok, data_data_ok}); end
    tick();
    #1;
    n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_bad++; $display("FAIL lock_resp1: got %b want 01", {inst_data_ok, data_data_ok}); end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_full();
    data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      data_addr = 32'h0000_3000 + 32'(4 * i);
      #1;
      n_cmp++; if (data_addr_ok !== 1'b1) begin n_bad++; $display("FAIL full_accept%0d: got %b want 1", i, data_addr_ok); end
      tick();
    end
    data_addr = 32'h0000_3010;
    #1;
    n_cmp++; if (dut.r_count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", dut.r_count); end
    n_cmp++; if ({mem_req, data_addr_ok} !== 2'b00) begin n_bad++; $display("FAIL full_block: got %b want 00", {mem_req, data_addr_ok}); end
    tick();
    mem_data_ok = 1;
    #1;
    n_cmp++; if ({data_data_ok, mem_req} !== 2'b10) begin n_bad++; $display("FAIL full_pop: got %b want 10", {data_data_ok, mem_req}); end
    tick();
    mem_data_ok = 0;
    #1;
    n_cmp++; if ({mem_req, data_addr_ok, mem_addr} !== {2'b11, 32'h0000_3010}) begin
      n_bad++; $display("FAIL full_refire: got %b%b/%h want 11/00003010", mem_req, data_addr_ok, mem_addr); end
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_bad++; $display("FAIL full_drain%0d: got %b want 01", i, {inst_data_ok, data_data_ok}); end
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_wrap();
    // Pointers sit at 2 here; one inst push moves wr_ptr to 3.
    inst_req = 1; inst_addr = 32'h1C00_0010; mem_addr_ok = 1;
    tick();
    inst_req = 0; data_req = 1; data_addr = 32'h0000_4000; mem_data_ok = 1;
    #1;
    n_cmp++; if ({data_addr_ok, inst_data_ok, data_data_ok} !== 3'b110) begin
      n_bad++; $display("FAIL wrap_push_pop: got %b want 110", {data_addr_ok, inst_data_ok, data_data_ok}); end
    tick();
    data_req = 0; mem_data_ok = 0; mem_addr_ok = 0;
    #1;
    n_cmp++; if ({dut.r_count, dut.r_wr_ptr} !== {3'd1, 2'd0}) begin
      n_bad++; $display("FAIL wrap_ptr: got count %0d wr %0d want 1/0", dut.r_count, dut.r_wr_ptr); end
    mem_addr_ok = 1;
    inst_req = 1; tick();
    tick();
    inst_req = 0; data_req = 1; tick();
    set_idle();
    mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp;
      exp = (i == 0 || i == 3) ? 2'b01 : 2'b10;
      #1;
      n_cmp++; if ({inst_data_ok, data_data_ok} !== exp) begin n_bad++; $display("FAIL wrap_resp%0d: got %b want %b", i, {inst_data_ok, data_data_ok}, exp); end
      tick();
    end
    set_idle();
    #1;
    n_cmp++; if (dut.r_count !== 3'd0) begin n_bad++; $display("FAIL wrap_count_end: got %0d want 0", dut.r_count); end
    tick();
  endtask

  task automatic test_resp_err();
    mem_data_ok = 1;
    #1;
    n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_bad++; $display("FAIL err_no_route: got %b want 00", {inst_data_ok, data_data_ok}); end
    tick();
    mem_data_ok = 0; inst_req = 1; mem_addr_ok = 1;
    #1;
    n_cmp++; if (resp_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", resp_err); end
    tick();
    set_idle();
    #1;
    n_cmp++; if (resp_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", resp_err); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if ({resp_err, dut.r_count} !== {1'b0, 3'd0}) begin
      n_bad++; $display("FAIL err_reset: got err %b count %0d want 0/0", resp_err, dut.r_count); end
    tick();
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_single_inst();
    test_priority();
    test_lock();
    test_full();
    test_wrap();
    test_resp_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
